// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU front-end: operand width, IP op codes and the issue FSM states.
package fpu_pkg;

  localparam int FPU_W = 32;

  localparam logic [7:0] OP_ADD = 8'h00;
  localparam logic [7:0] OP_SUB = 8'h01;
  localparam logic [7:0] OP_EQ  = 8'h14;
  localparam logic [7:0] OP_LT  = 8'h0C;
  localparam logic [7:0] OP_LE  = 8'h1C;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

endpackage

// File: rtl/fpu_tag_fifo.sv
// In-order tag FIFO: remembers which requester issued each op still inside the IP pipeline.
module fpu_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int TW    = 1,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          push,
  input  logic [TW-1:0] push_tag,
  input  logic          pop,
  output logic [TW-1:0] head_tag,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [TW-1:0] mem_q [DEPTH];
  logic [TW-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_tag;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    // Simultaneous push and pop leaves the occupancy unchanged.
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_tag = mem_q[rd_ptr_q];
  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;

endmodule

// File: rtl/fpu_shared_unit_arbiter.sv
// Round-robin front-end sharing one AXI-Stream FP operator between NREQ requesters,
// issuing a/b/op independently and steering in-order results back to their issuers.
module fpu_shared_unit_arbiter
  import fpu_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int DEPTH = 4,
  parameter int W     = FPU_W,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ*8-1:0] req_op,
  output logic [NREQ-1:0]   resp_valid,
  output logic [W-1:0]      resp_data,
  input  logic [NREQ-1:0]   resp_ready,
  output logic [W-1:0]      ip_a_tdata,
  output logic              ip_a_tvalid,
  input  logic              ip_a_tready,
  output logic [W-1:0]      ip_b_tdata,
  output logic              ip_b_tvalid,
  input  logic              ip_b_tready,
  output logic [7:0]        ip_op_tdata,
  output logic              ip_op_tvalid,
  input  logic              ip_op_tready,
  input  logic [W-1:0]      ip_r_tdata,
  input  logic              ip_r_tvalid,
  output logic              ip_r_tready,
  output logic              busy,
  output logic              err_orphan,
  output state_t            dbg_state,
  output logic [CW-1:0]     dbg_count
);

  localparam int TW = $clog2(NREQ);
  localparam logic [TW:0] NREQ_L = (TW+1)'(NREQ);

  // Every channel transfers on the cycle valid and ready are both high; a source
  // never lowers valid or changes data before that cycle, and valid never waits on ready.

  state_t        state_q, state_d;
  logic [TW-1:0] rr_ptr_q, rr_ptr_d;
  logic [TW-1:0] tag_q, tag_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d;
  logic [7:0]    op_q, op_d;
  logic          done_a_q, done_a_d, done_b_q, done_b_d, done_op_q, done_op_d;
  logic          err_orphan_q, err_orphan_d;

  logic          grant_found, grant_en;
  logic [TW-1:0] grant_idx;
  logic [TW:0]   scan;
  logic          hs_a, hs_b, hs_op, all_done;
  logic          push, pop, full, empty;
  logic [TW-1:0] head_tag;
  logic [CW-1:0] fifo_count;

  // Rotating priority: first valid requester at or after rr_ptr, wrapping at NREQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan        = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan = {1'b0, rr_ptr_q} + (TW+1)'(k);
      if (scan >= NREQ_L) scan = scan - NREQ_L;
      if (!grant_found && req_valid[scan[TW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = scan[TW-1:0];
      end
    end
  end

  assign grant_en  = RST_N && (state_q == IDLE) && grant_found && !full;
  assign req_ready = grant_en ? (NREQ'(1) << grant_idx) : '0;

  assign ip_a_tvalid  = (state_q == ISSUE) && !done_a_q;
  assign ip_b_tvalid  = (state_q == ISSUE) && !done_b_q;
  assign ip_op_tvalid = (state_q == ISSUE) && !done_op_q;
  assign ip_a_tdata   = a_q;
  assign ip_b_tdata   = b_q;
  assign ip_op_tdata  = op_q;

  assign hs_a     = ip_a_tvalid && ip_a_tready;
  assign hs_b     = ip_b_tvalid && ip_b_tready;
  assign hs_op    = ip_op_tvalid && ip_op_tready;
  assign all_done = (done_a_q || hs_a) && (done_b_q || hs_b) && (done_op_q || hs_op);
  assign push     = (state_q == ISSUE) && all_done;

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    tag_d        = tag_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    done_a_d     = done_a_q;
    done_b_d     = done_b_q;
    done_op_d    = done_op_q;
    err_orphan_d = err_orphan_q || (ip_r_tvalid && empty);
    case (state_q)
      IDLE: begin
        if (grant_en) begin
          a_d       = req_a[grant_idx*W +: W];
          b_d       = req_b[grant_idx*W +: W];
          op_d      = req_op[grant_idx*8 +: 8];
          tag_d     = grant_idx;
          done_a_d  = 1'b0;
          done_b_d  = 1'b0;
          done_op_d = 1'b0;
          rr_ptr_d  = (grant_idx == TW'(NREQ-1)) ? '0 : grant_idx + TW'(1);
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        done_a_d  = done_a_q || hs_a;
        done_b_d  = done_b_q || hs_b;
        done_op_d = done_op_q || hs_op;
        if (all_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      tag_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      done_a_q     <= 1'b0;
      done_b_q     <= 1'b0;
      done_op_q    <= 1'b0;
      err_orphan_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      tag_q        <= tag_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      done_a_q     <= done_a_d;
      done_b_q     <= done_b_d;
      done_op_q    <= done_op_d;
      err_orphan_q <= err_orphan_d;
    end
  end

  fpu_tag_fifo #(
    .DEPTH (DEPTH),
    .TW    (TW),
    .CW    (CW)
  ) u_tag_fifo (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .push     (push),
    .push_tag (tag_q),
    .pop      (pop),
    .head_tag (head_tag),
    .full     (full),
    .empty    (empty),
    .count    (fifo_count)
  );

  // Results come back in issue order, so the FIFO head names the owner.
  assign resp_valid  = (!empty && ip_r_tvalid) ? (NREQ'(1) << head_tag) : '0;
  assign resp_data   = ip_r_tdata;
  assign ip_r_tready = !empty && resp_ready[head_tag];
  assign pop         = ip_r_tvalid && ip_r_tready;

  assign busy       = (state_q != IDLE) || (fifo_count != '0);
  assign err_orphan = err_orphan_q;
  assign dbg_state  = state_q;
  assign dbg_count  = fifo_count;

endmodule

// File: tb/tb_fpu_shared_unit_arbiter.sv
// Directed bench for fpu_shared_unit_arbiter: grant order, issue sequencing, result routing, full/orphan/reset.
module tb_fpu_shared_unit_arbiter;
  import fpu_pkg::*;

  localparam int NREQ  = 2;
  localparam int DEPTH = 4;
  localparam int W     = 32;
  localparam int CW    = 3;

  logic              CLK;
  logic              RST_N;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ*8-1:0] req_op;
  logic [NREQ-1:0]   resp_valid;
  logic [W-1:0]      resp_data;
  logic [NREQ-1:0]   resp_ready;
  logic [W-1:0]      ip_a_tdata;
  logic              ip_a_tvalid;
  logic              ip_a_tready;
  logic [W-1:0]      ip_b_tdata;
  logic              ip_b_tvalid;
  logic              ip_b_tready;
  logic [7:0]        ip_op_tdata;
  logic              ip_op_tvalid;
  logic              ip_op_tready;
  logic [W-1:0]      ip_r_tdata;
  logic              ip_r_tvalid;
  logic              ip_r_tready;
  logic              busy;
  logic              err_orphan;
  state_t            dbg_state;
  logic [CW-1:0]     dbg_count;

  int checks;
  int errors;

  fpu_shared_unit_arbiter #(
    .NREQ  (NREQ),
    .DEPTH (DEPTH),
    .W     (W),
    .CW    (CW)
  ) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_op       (req_op),
    .resp_valid   (resp_valid),
    .resp_data    (resp_data),
    .resp_ready   (resp_ready),
    .ip_a_tdata   (ip_a_tdata),
    .ip_a_tvalid  (ip_a_tvalid),
    .ip_a_tready  (ip_a_tready),
    .ip_b_tdata   (ip_b_tdata),
    .ip_b_tvalid  (ip_b_tvalid),
    .ip_b_tready  (ip_b_tready),
    .ip_op_tdata  (ip_op_tdata),
    .ip_op_tvalid (ip_op_tvalid),
    .ip_op_tready (ip_op_tready),
    .ip_r_tdata   (ip_r_tdata),
    .ip_r_tvalid  (ip_r_tvalid),
    .ip_r_tready  (ip_r_tready),
    .busy         (busy),
    .err_orphan   (err_orphan),
    .dbg_state    (dbg_state),
    .dbg_count    (dbg_count)
  );

  // Clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    RST_N        = 1'b0;
    req_valid    = '0;
    req_a        = '0;
    req_b        = '0;
    req_op       = '0;
    resp_ready   = '0;
    ip_a_tready  = 1'b0;
    ip_b_tready  = 1'b0;
    ip_op_tready = 1'b0;
    ip_r_tdata   = '0;
    ip_r_tvalid  = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic test_reset();
    RST_N        = 1'b0;
    req_valid    = '0;
    req_a        = '0;
    req_b        = '0;
    req_op       = '0;
    resp_ready   = '0;
    ip_a_tready  = 1'b0;
    ip_b_tready  = 1'b0;
    ip_op_tready = 1'b0;
    ip_r_tdata   = '0;
    ip_r_tvalid  = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    checks++;
    if ({ip_a_tvalid, ip_b_tvalid, ip_op_tvalid} !== 3'b000) begin
      errors++; $display("FAIL reset_tvalid got %b exp 000", {ip_a_tvalid, ip_b_tvalid, ip_op_tvalid});
    end
    checks++;
    if ({req_ready, resp_valid, ip_r_tready, busy, err_orphan} !== 7'b0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 0000000", {req_ready, resp_valid, ip_r_tready, busy, err_orphan});
    end
    checks++;
    if (dbg_state !== IDLE || dbg_count !== 3'd0) begin
      errors++; $display("FAIL reset_state got state %0d count %0d exp 0 0", dbg_state, dbg_count);
    end
    checks++;
    if ({ip_a_tdata, ip_b_tdata, ip_op_tdata} !== 72'h0) begin
      errors++; $display("FAIL reset_tdata got %h exp 0", {ip_a_tdata, ip_b_tdata, ip_op_tdata});
    end
    RST_N = 1'b1;
  endtask

  task automatic test_single_op();
    apply_reset();
    ip_a_tready  = 1'b1;
    ip_b_tready  = 1'b1;
    ip_op_tready = 1'b1;
    req_valid    = 2'b01;
    req_a        = {32'h0, 32'h3F800000};
    req_b        = {32'h0, 32'h40000000};
    req_op       = {8'h00, OP_ADD};
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++; $display("FAIL single_req_ready got %b exp 01", req_ready);
    end
    @(negedge CLK);
    req_valid = '0;
    #1;
    checks++;
    if ({ip_a_tvalid, ip_b_tvalid, ip_op_tvalid} !== 3'b111 || dbg_state !== ISSUE) begin
      errors++; $display("FAIL single_issue_tvalid got %b state %0d exp 111 state 1",
                         {ip_a_tvalid, ip_b_tvalid, ip_op_tvalid}, dbg_state);
    end
    checks++;
    if (ip_a_tdata !== 32'h3F800000 || ip_b_tdata !== 32'h40000000 || ip_op_tdata !== OP_ADD) begin
      errors++; $display("FAIL single_issue_tdata got %h %h %h exp 3f800000 40000000 00",
                         ip_a_tdata, ip_b_tdata, ip_op_tdata);
    end
    @(negedge CLK);
    #1;
    checks++;
    if ({ip_a_tvalid, ip_b_tvalid, ip_op_tvalid} !== 3'b000 || dbg_count !== 3'd1 || busy !== 1'b1) begin
      errors++; $display("FAIL single_after_issue got tvalid %b count %0d busy %b exp 000 1 1",
                         {ip_a_tvalid, ip_b_tvalid, ip_op_tvalid}, dbg_count, busy);
    end
    repeat (6) @(negedge CLK);
    ip_r_tvalid = 1'b1;
    ip_r_tdata  = 32'h40400000;
    resp_ready  = 2'b01;
    #1;
    checks++;
    if (resp_valid !== 2'b01 || resp_data !== 32'h40400000 || ip_r_tready !== 1'b1) begin
      errors++; $display("FAIL single_resp got valid %b data %h rdy %b exp 01 40400000 1",
                         resp_valid, resp_data, ip_r_tready);
    end
    @(negedge CLK);
    ip_r_tvalid = 1'b0;
    resp_ready  = '0;
    #1;
    checks++;
    if (dbg_count !== 3'd0 || busy !== 1'b0 || resp_valid !== 2'b00) begin
      errors++; $display("FAIL single_drain got count %0d busy %b resp_valid %b exp 0 0 00",
                         dbg_count, busy, resp_valid);
    end
  endtask

  task automatic test_contention();
    logic [1:0]  exp_g [4];
    logic [31:0] exp_a;
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
    apply_reset();
    ip_a_tready  = 1'b1;
    ip_b_tready  = 1'b1;
    ip_op_tready = 1'b1;
    req_a        = {32'h22222222, 32'h11111111};
    req_op       = {OP_SUB, OP_ADD};
    req_valid    = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (req_ready !== exp_g[k]) begin
        errors++; $display("FAIL contention_grant%0d got %b exp %b", k, req_ready, exp_g[k]);
      end
      @(negedge CLK);
      if (k == 3) req_valid = '0;
      exp_a = (k % 2 == 0) ? 32'h11111111 : 32'h22222222;
      #1;
      checks++;
      if (ip_a_tdata !== exp_a) begin
        errors++; $display("FAIL contention_tdata%0d got %h exp %h", k, ip_a_tdata, exp_a);
      end
      @(negedge CLK);
    end
    #1;
    checks++;
    if (dbg_count !== 3'd4) begin
      errors++; $display("FAIL contention_count got %0d exp 4", dbg_count);
    end
    resp_ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      ip_r_tvalid = 1'b1;
      ip_r_tdata  = 32'hA0 + k;
      #1;
      checks++;
      if (resp_valid !== exp_g[k] || resp_data !== 32'hA0 + k) begin
        errors++; $display("FAIL contention_resp%0d got %b %h exp %b %h", k, resp_valid, resp_data,
                           exp_g[k], 32'hA0 + k);
      end
      @(negedge CLK);
    end
    ip_r_tvalid = 1'b0;
    resp_ready  = '0;
    #1;
    checks++;
    if (dbg_count !== 3'd0) begin
      errors++; $display("FAIL contention_drain got %0d exp 0", dbg_count);
    end
  endtask

  task automatic test_staggered();
    apply_reset();
    ip_a_tready  = 1'b1;
    ip_b_tready  = 1'b0;
    ip_op_tready = 1'b1;
    req_valid    = 2'b01;
    req_a        = {32'h0, 32'hAAAA0001};
    req_b        = {32'h0, 32'hBBBB0001};
    req_op       = {8'h00, OP_LT};
    @(negedge CLK);
    req_valid = '0;
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) ip_b_tready = 1'b1;
      #1;
      checks++;
      if (ip_b_tvalid !== 1'b1 || ip_b_tdata !== 32'hBBBB0001 || dbg_state !== ISSUE) begin
        errors++; $display("FAIL stagger_b_c%0d got %b %h state %0d exp 1 bbbb0001 1",
                           c, ip_b_tvalid, ip_b_tdata, dbg_state);
      end
      checks++;
      if (ip_a_tvalid !== (c == 1) || ip_op_tvalid !== (c == 1)) begin
        errors++; $display("FAIL stagger_a_op_c%0d got %b %b exp %b", c, ip_a_tvalid, ip_op_tvalid, (c == 1));
      end
      @(negedge CLK);
    end
    #1;
    checks++;
    if (dbg_state !== IDLE || dbg_count !== 3'd1 || ip_b_tvalid !== 1'b0) begin
      errors++; $display("FAIL stagger_done got state %0d count %0d b %b exp 0 1 0",
                         dbg_state, dbg_count, ip_b_tvalid);
    end
    repeat (3) @(negedge CLK);
    #1;
    checks++;
    if (dbg_count !== 3'd1) begin
      errors++; $display("FAIL stagger_one_push got %0d exp 1", dbg_count);
    end
  endtask

  task automatic test_full();
    int grants;
    apply_reset();
    ip_a_tready  = 1'b1;
    ip_b_tready  = 1'b1;
    ip_op_tready = 1'b1;
    req_valid    = 2'b01;
    grants = 0;
    repeat (12) begin
      #1;
      if (req_ready !== 2'b00) grants++;
      @(negedge CLK);
    end
    #1;
    checks++;
    if (grants !== 4) begin
      errors++; $display("FAIL full_grants got %0d exp 4", grants);
    end
    checks++;
    if (req_ready !== 2'b00 || busy !== 1'b1 || dbg_count !== 3'd4) begin
      errors++; $display("FAIL full_stall got rdy %b busy %b count %0d exp 00 1 4", req_ready, busy, dbg_count);
    end
    ip_r_tvalid = 1'b1;
    resp_ready  = 2'b01;
    @(negedge CLK);
    ip_r_tvalid = 1'b0;
    resp_ready  = '0;
    #1;
    checks++;
    if (dbg_count !== 3'd3) begin
      errors++; $display("FAIL full_pop got %0d exp 3", dbg_count);
    end
    grants = 0;
    repeat (8) begin
      #1;
      if (req_ready !== 2'b00) grants++;
      @(negedge CLK);
    end
    #1;
    checks++;
    if (grants !== 1 || dbg_count !== 3'd4) begin
      errors++; $display("FAIL full_refill got grants %0d count %0d exp 1 4", grants, dbg_count);
    end
  endtask

  // Continues from the full state left by test_full.
  task automatic test_backpressure();
    ip_r_tvalid = 1'b1;
    ip_r_tdata  = 32'hC0;
    resp_ready  = '0;
    #1;
    checks++;
    if (ip_r_tready !== 1'b0 || resp_valid !== 2'b01) begin
      errors++; $display("FAIL bp_hold got rdy %b valid %b exp 0 01", ip_r_tready, resp_valid);
    end
    @(negedge CLK);
    #1;
    checks++;
    if (dbg_count !== 3'd4) begin
      errors++; $display("FAIL bp_count_hold got %0d exp 4", dbg_count);
    end
    ip_b_tready = 1'b0;
    resp_ready  = 2'b01;
    @(negedge CLK);
    resp_ready  = '0;
    ip_r_tvalid = 1'b0;
    #1;
    checks++;
    if (dbg_count !== 3'd3 || req_ready !== 2'b01) begin
      errors++; $display("FAIL bp_release got count %0d rdy %b exp 3 01", dbg_count, req_ready);
    end
    @(negedge CLK);
    @(negedge CLK);
    ip_b_tready = 1'b1;
    ip_r_tvalid = 1'b1;
    resp_ready  = 2'b01;
    #1;
    checks++;
    if (ip_b_tvalid !== 1'b1 || ip_r_tready !== 1'b1 || dbg_state !== ISSUE) begin
      errors++; $display("FAIL bp_simul_setup got b %b rdy %b state %0d exp 1 1 1",
                         ip_b_tvalid, ip_r_tready, dbg_state);
    end
    @(negedge CLK);
    ip_r_tvalid = 1'b0;
    resp_ready  = '0;
    req_valid   = '0;
    #1;
    checks++;
    if (dbg_count !== 3'd3 || dbg_state !== IDLE) begin
      errors++; $display("FAIL bp_simul_count got count %0d state %0d exp 3 0", dbg_count, dbg_state);
    end
  endtask

  task automatic test_orphan_reset();
    apply_reset();
    ip_r_tvalid = 1'b1;
    ip_r_tdata  = 32'hDEAD;
    #1;
    checks++;
    if (ip_r_tready !== 1'b0 || resp_valid !== 2'b00) begin
      errors++; $display("FAIL orphan_no_route got rdy %b valid %b exp 0 00", ip_r_tready, resp_valid);
    end
    @(negedge CLK);
    ip_r_tvalid = 1'b0;
    #1;
    checks++;
    if (err_orphan !== 1'b1) begin
      errors++; $display("FAIL orphan_set got %b exp 1", err_orphan);
    end
    @(negedge CLK);
    #1;
    checks++;
    if (err_orphan !== 1'b1) begin
      errors++; $display("FAIL orphan_sticky got %b exp 1", err_orphan);
    end
    ip_a_tready  = 1'b1;
    ip_b_tready  = 1'b1;
    ip_op_tready = 1'b1;
    req_valid    = 2'b11;
    repeat (6) @(negedge CLK);
    req_valid = '0;
    #1;
    checks++;
    if (dbg_count !== 3'd3 || busy !== 1'b1) begin
      errors++; $display("FAIL inflight_count got %0d busy %b exp 3 1", dbg_count, busy);
    end
    RST_N       = 1'b0;
    req_valid   = 2'b11;
    ip_r_tvalid = 1'b1;
    #1;
    checks++;
    if (req_ready !== 2'b00) begin
      errors++; $display("FAIL reset_no_grant got %b exp 00", req_ready);
    end
    @(negedge CLK);
    #1;
    checks++;
    if (dbg_count !== 3'd0 || busy !== 1'b0 || err_orphan !== 1'b0 || dbg_state !== IDLE) begin
      errors++; $display("FAIL midreset_state got count %0d busy %b orphan %b state %0d exp 0 0 0 0",
                         dbg_count, busy, err_orphan, dbg_state);
    end
    checks++;
    if ({req_ready, resp_valid, ip_r_tready, ip_a_tvalid, ip_b_tvalid, ip_op_tvalid} !== 8'b0) begin
      errors++; $display("FAIL midreset_outputs got %b exp 00000000",
                         {req_ready, resp_valid, ip_r_tready, ip_a_tvalid, ip_b_tvalid, ip_op_tvalid});
    end
    req_valid   = '0;
    ip_r_tvalid = 1'b0;
    RST_N       = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_op();
    test_contention();
    test_staggered();
    test_full();
    test_backpressure();
    test_orphan_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
